// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the byte-wide memory controller.
package mem_ctrl_pkg;

  localparam int ADDR_WID        = 32;
  localparam int ICACHE_BLK_SIZE = 64;
  localparam int IF_BYTES        = ICACHE_BLK_SIZE;
  localparam int IF_DATA_WID     = 8 * IF_BYTES;
  localparam int LSB_DATA_WID    = 32;
  localparam int CNT_WID         = 7;

  // Transfer length of a fetch block in counter units
  localparam logic [CNT_WID-1:0] IF_LEN = CNT_WID'(IF_BYTES);

  // addr[17:16] value that selects the IO space
  localparam logic [1:0] IO_ADDR_HI = 2'b11;

  typedef enum logic [1:0] {
    MC_IDLE     = 2'd0,
    MC_IF_READ  = 2'd1,
    MC_LS_READ  = 2'd2,
    MC_LS_WRITE = 2'd3
  } mc_state_e;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_LSB = 1'b1
  } grant_e;

  // True when the upper address bits point into IO space
  function automatic logic is_io_hi(input logic [1:0] addr_hi);
    return addr_hi == IO_ADDR_HI;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide RAM/IO port between instruction fetch and the
// load/store buffer, serialising each request into per-byte RAM cycles.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_WID-1:0]     mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic                    if_en,
  input  logic [ADDR_WID-1:0]     if_pc,
  output logic                    if_done,
  output logic [IF_DATA_WID-1:0]  if_data,
  input  logic                    lsb_en,
  input  logic                    lsb_wr,
  input  logic [ADDR_WID-1:0]     lsb_addr,
  input  logic [2:0]              lsb_len,
  input  logic [LSB_DATA_WID-1:0] lsb_w_data,
  output logic                    lsb_done,
  output logic [LSB_DATA_WID-1:0] lsb_r_data,
  input  logic                    rob_clear
);

  mc_state_e               state_q;
  grant_e                  last_grant_q;
  logic [CNT_WID-1:0]      cnt_q;
  logic [CNT_WID-1:0]      xfer_len_q;
  logic [ADDR_WID-1:0]     base_q;
  logic [LSB_DATA_WID-1:0] wdata_q;
  logic [IF_DATA_WID-1:0]  asm_q;
  logic [IF_DATA_WID-1:0]  asm_d;

  logic [7:0]              mem_dout_q;
  logic [ADDR_WID-1:0]     mem_a_q;
  logic                    mem_wr_q;
  logic                    if_done_q;
  logic                    lsb_done_q;
  logic [IF_DATA_WID-1:0]  if_data_q;
  logic [LSB_DATA_WID-1:0] lsb_r_data_q;

  logic                    if_req;
  logic                    lsb_req;
  logic                    grant_if;
  logic                    grant_lsb;
  logic [5:0]              lane_idx;
  logic [ADDR_WID-1:0]     next_addr;

  assign mem_dout   = mem_dout_q;
  assign mem_a      = mem_a_q;
  assign mem_wr     = mem_wr_q;
  assign if_done    = if_done_q;
  assign lsb_done   = lsb_done_q;
  assign if_data    = if_data_q;
  assign lsb_r_data = lsb_r_data_q;

  // Round-robin arbitration; a requester whose done pulse is out this cycle
  // still holds en, so its request is masked until it has dropped it.
  always_comb begin
    if_req    = if_en && !if_done_q;
    lsb_req   = lsb_en && !lsb_done_q;
    grant_lsb = lsb_req && (!if_req || (last_grant_q != GRANT_LSB));
    grant_if  = if_req && !grant_lsb;
  end

  // Byte lane assembly: mem_din carries the byte whose address went out two
  // counts ago, so it lands in lane cnt-2 (mod 64 keeps the index 6 bits).
  always_comb begin
    next_addr = base_q + {{(ADDR_WID-CNT_WID){1'b0}}, cnt_q};
    lane_idx  = cnt_q[5:0] - 6'd2;
    asm_d     = asm_q;
    if (((state_q == MC_IF_READ) || (state_q == MC_LS_READ)) && (cnt_q >= 7'd2)) begin
      asm_d[{lane_idx, 3'b000} +: 8] = mem_din;
    end
  end

  // Controller FSM with registered RAM-side and requester-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MC_IDLE;
      last_grant_q <= GRANT_IF;
      cnt_q        <= '0;
      xfer_len_q   <= '0;
      base_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
      mem_dout_q   <= '0;
      mem_a_q      <= '0;
      mem_wr_q     <= 1'b0;
      if_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
      if_data_q    <= '0;
      lsb_r_data_q <= '0;
    end else if (rdy) begin
      if_done_q  <= 1'b0;
      lsb_done_q <= 1'b0;
      case (state_q)
        MC_IDLE: begin
          mem_wr_q <= 1'b0;
          if (!rob_clear && grant_lsb) begin
            last_grant_q <= GRANT_LSB;
            base_q       <= lsb_addr;
            wdata_q      <= lsb_w_data;
            xfer_len_q   <= {4'b0000, lsb_len};
            asm_q        <= '0;
            mem_a_q      <= lsb_addr;
            if (lsb_wr) begin
              state_q <= MC_LS_WRITE;
              // Byte 0 is issued from this edge, so the IO stall test
              // already applies here.
              if (is_io_hi(lsb_addr[17:16]) && io_buffer_full) begin
                cnt_q <= '0;
              end else begin
                mem_wr_q   <= 1'b1;
                mem_dout_q <= lsb_w_data[7:0];
                cnt_q      <= 7'd1;
              end
            end else begin
              state_q <= MC_LS_READ;
              cnt_q   <= 7'd1;
            end
          end else if (!rob_clear && grant_if) begin
            last_grant_q <= GRANT_IF;
            state_q      <= MC_IF_READ;
            base_q       <= if_pc;
            xfer_len_q   <= IF_LEN;
            asm_q        <= '0;
            mem_a_q      <= if_pc;
            cnt_q        <= 7'd1;
          end
        end

        MC_IF_READ, MC_LS_READ: begin
          mem_wr_q <= 1'b0;
          if (rob_clear) begin
            // Flushed reads are simply abandoned, no done pulse.
            state_q <= MC_IDLE;
            cnt_q   <= '0;
          end else begin
            asm_q <= asm_d;
            if (cnt_q == (xfer_len_q + 7'd1)) begin
              state_q <= MC_IDLE;
              cnt_q   <= '0;
              if (state_q == MC_IF_READ) begin
                if_done_q <= 1'b1;
                if_data_q <= asm_d;
              end else begin
                lsb_done_q   <= 1'b1;
                lsb_r_data_q <= asm_d[LSB_DATA_WID-1:0];
              end
            end else begin
              cnt_q <= cnt_q + 7'd1;
              if (cnt_q < xfer_len_q) begin
                mem_a_q <= next_addr;
              end
            end
          end
        end

        MC_LS_WRITE: begin
          // Committed stores ignore rob_clear and always complete.
          if (cnt_q == xfer_len_q) begin
            mem_wr_q   <= 1'b0;
            lsb_done_q <= 1'b1;
            state_q    <= MC_IDLE;
            cnt_q      <= '0;
          end else if (is_io_hi(base_q[17:16]) && io_buffer_full) begin
            mem_wr_q <= 1'b0;
          end else begin
            mem_wr_q   <= 1'b1;
            mem_a_q    <= next_addr;
            mem_dout_q <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            cnt_q      <= cnt_q + 7'd1;
          end
        end

        default: begin
          state_q  <= MC_IDLE;
          mem_wr_q <= 1'b0;
          cnt_q    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with a byte-wide RAM model.
module tb_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  logic [7:0]   mem_din = 8'h00;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         io_buffer_full;
  logic         if_en;
  logic [31:0]  if_pc;
  logic         if_done;
  logic [511:0] if_data;
  logic         lsb_en;
  logic         lsb_wr;
  logic [31:0]  lsb_addr;
  logic [2:0]   lsb_len;
  logic [31:0]  lsb_w_data;
  logic         lsb_done;
  logic [31:0]  lsb_r_data;
  logic         rob_clear;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [511:0] if_exp_q[$];
  logic [31:0]  lsb_exp_q[$];
  wr_t          wr_exp_q[$];

  logic [7:0] ram [0:262143];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data),
    .rob_clear(rob_clear)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read byte appears the cycle after its address; frozen by rdy.
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
      mem_din <= ram[mem_a[17:0]];
    end
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [511:0] blk(input logic [31:0] base);
    logic [511:0] b;
    logic [31:0]  a;
    for (int k = 0; k < 64; k++) begin
      a = base + k;
      b[8*k +: 8] = a[7:0];
    end
    return b;
  endfunction

  task automatic lsb_start(input logic wr, input logic [31:0] addr, input logic [2:0] len,
                           input logic [31:0] wd);
    lsb_wr     = wr;
    lsb_addr   = addr;
    lsb_len    = len;
    lsb_w_data = wd;
    lsb_en     = 1'b1;
  endtask

  task automatic wait_done(input logic is_if, input int g, input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (is_if ? if_done : lsb_done) begin
        lat = cyc - g;
        break;
      end
    end
  endtask

  // Scoreboard: compare every done pulse and every RAM write against the queues
  logic [511:0] sb_blk;
  logic [31:0]  sb_word;
  wr_t          sb_wr;
  always @(negedge clk) begin
    if (if_done) begin
      check("if_done_expected", (if_exp_q.size() != 0), 1'b1);
      if (if_exp_q.size() != 0) begin
        sb_blk = if_exp_q.pop_front();
        check("if_data", if_data, sb_blk);
        $display("[%0d] if_done data[7:0]=%h data[511:504]=%h", cyc, if_data[7:0], if_data[511:504]);
      end
    end
    if (lsb_done) begin
      check("lsb_done_expected", (lsb_exp_q.size() != 0), 1'b1);
      if (lsb_exp_q.size() != 0) begin
        sb_word = lsb_exp_q.pop_front();
        check("lsb_r_data", lsb_r_data, sb_word);
        $display("[%0d] lsb_done r_data=%h", cyc, lsb_r_data);
      end
    end
    if (mem_wr && rdy) begin
      check("wr_expected", (wr_exp_q.size() != 0), 1'b1);
      if (wr_exp_q.size() != 0) begin
        sb_wr = wr_exp_q.pop_front();
        check("wr_addr", mem_a, sb_wr.a);
        check("wr_data", mem_dout, sb_wr.d);
        $display("[%0d] write a=%h d=%h", cyc, mem_a, mem_dout);
      end
    end
  end

  initial begin
    int g;
    int lat;
    int nd;

    for (int i = 0; i < 262144; i++) ram[i] = 8'(i);
    ram[18'h2002] = 8'h11;
    ram[18'h2003] = 8'h22;
    ram[18'h2004] = 8'h33;
    ram[18'h2005] = 8'h44;

    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; rob_clear = 1'b0;
    if_en = 1'b0; if_pc = '0;
    lsb_en = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_w_data = '0;
    repeat (3) step();

    // Reset values
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", mem_dout, 8'h0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_if_done", if_done, 1'b0);
    check("rst_lsb_done", lsb_done, 1'b0);
    check("rst_if_data", if_data, 512'h0);
    check("rst_lsb_r_data", lsb_r_data, 32'h0);
    rst = 1'b0;
    step();

    // IF fetch of block 0x1000
    if_exp_q.push_back(blk(32'h1000));
    if_pc = 32'h1000; if_en = 1'b1; g = cyc;
    for (int k = 1; k <= 64; k++) begin
      step();
      check("if_mem_a", mem_a, 32'h1000 + k - 1);
      check("if_mem_wr", mem_wr, 1'b0);
    end
    wait_done(1'b1, g, 10, lat);
    check("if_lat", lat, 66);
    check("if_byte0", if_data[7:0], 8'h00);
    check("if_byte63", if_data[511:504], 8'h3F);
    step(); if_en = 1'b0;
    step(); step();
    check("if_hold", if_data, blk(32'h1000));

    // 4-byte load at 0x2002
    lsb_exp_q.push_back(32'h44332211);
    lsb_start(1'b0, 32'h2002, 3'd4, 32'h0); g = cyc;
    wait_done(1'b0, g, 20, lat);
    check("ld4_lat", lat, 6);
    step(); lsb_en = 1'b0; step();

    // 2-byte load: upper half must be zero
    lsb_exp_q.push_back(32'h00004433);
    lsb_start(1'b0, 32'h2004, 3'd2, 32'h0); g = cyc;
    wait_done(1'b0, g, 20, lat);
    check("ld2_lat", lat, 4);
    check("ld2_upper", lsb_r_data[31:16], 16'h0);
    step(); lsb_en = 1'b0; step();

    // 1-byte load
    lsb_exp_q.push_back(32'h00000020);
    lsb_start(1'b0, 32'h20, 3'd1, 32'h0); g = cyc;
    wait_done(1'b0, g, 20, lat);
    check("ld1_lat", lat, 3);
    step(); lsb_en = 1'b0; step();

    // rdy low for two edges mid-load freezes everything
    lsb_exp_q.push_back(32'h44332211);
    lsb_start(1'b0, 32'h2002, 3'd4, 32'h0); g = cyc;
    step(); step();
    check("frz_a2", mem_a, 32'h2003);
    rdy = 1'b0;
    step();
    check("frz_a3", mem_a, 32'h2003);
    step();
    check("frz_a4", mem_a, 32'h2003);
    rdy = 1'b1;
    wait_done(1'b0, g, 20, lat);
    check("frz_lat", lat, 8);
    step(); lsb_en = 1'b0; step();

    // 1-byte IO store with io_buffer_full high for 3 cycles
    wr_exp_q.push_back('{a: 32'h30000, d: 8'hD8});
    lsb_exp_q.push_back(32'h44332211);
    lsb_start(1'b1, 32'h30000, 3'd1, 32'hA5B6C7D8); io_buffer_full = 1'b1; g = cyc;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("io_stall_wr", mem_wr, 1'b0);
    end
    io_buffer_full = 1'b0;
    step();
    check("io_wr", mem_wr, 1'b1);
    check("io_dout", mem_dout, 8'hD8);
    wait_done(1'b0, g, 20, lat);
    check("io_lat", lat, 5);
    check("io_done_wr", mem_wr, 1'b0);
    step(); lsb_en = 1'b0; step();

    // 4-byte store with rob_clear during it: all bytes land
    wr_exp_q.push_back('{a: 32'h400, d: 8'h44});
    wr_exp_q.push_back('{a: 32'h401, d: 8'h33});
    wr_exp_q.push_back('{a: 32'h402, d: 8'h22});
    wr_exp_q.push_back('{a: 32'h403, d: 8'h11});
    lsb_exp_q.push_back(32'h44332211);
    lsb_start(1'b1, 32'h400, 3'd4, 32'h11223344); g = cyc;
    step(); rob_clear = 1'b1;
    step(); step(); rob_clear = 1'b0;
    wait_done(1'b0, g, 20, lat);
    check("st4_lat", lat, 5);
    step(); lsb_en = 1'b0; step();

    // Read the stored word back
    lsb_exp_q.push_back(32'h11223344);
    lsb_start(1'b0, 32'h400, 3'd4, 32'h0); g = cyc;
    wait_done(1'b0, g, 20, lat);
    check("rb_lat", lat, 6);
    step(); lsb_en = 1'b0; step();

    // From reset both request together: LSB first, IF in LSB done cycle,
    // then a second LSB request waits for the whole fetch
    rst = 1'b1; step(); step(); rst = 1'b0;
    lsb_exp_q.push_back(32'h44332211);
    if_exp_q.push_back(blk(32'h1040));
    if_pc = 32'h1040; if_en = 1'b1;
    lsb_start(1'b0, 32'h2002, 3'd4, 32'h0); g = cyc;
    wait_done(1'b0, g, 20, lat);
    check("arb_lsb_lat", lat, 6);
    step();
    check("arb_if_a", mem_a, 32'h1040);
    lsb_exp_q.push_back(32'h00000005);
    lsb_start(1'b0, 32'h5, 3'd1, 32'h0);
    wait_done(1'b1, g, 100, lat);
    check("arb_if_lat", lat, 72);
    step();
    check("arb_lsb2_a", mem_a, 32'h5);
    if_en = 1'b0;
    wait_done(1'b0, g, 20, lat);
    check("arb_lsb2_lat", lat, 75);
    step(); lsb_en = 1'b0; step();

    // Both together with last grant LSB: IF goes first
    if_exp_q.push_back(blk(32'h1000));
    lsb_exp_q.push_back(32'h00000007);
    if_pc = 32'h1000; if_en = 1'b1;
    lsb_start(1'b0, 32'h7, 3'd1, 32'h0); g = cyc;
    step();
    check("rr_if_a", mem_a, 32'h1000);
    wait_done(1'b1, g, 80, lat);
    check("rr_if_lat", lat, 66);
    step();
    check("rr_lsb_a", mem_a, 32'h7);
    if_en = 1'b0;
    wait_done(1'b0, g, 20, lat);
    check("rr_lsb_lat", lat, 69);
    step(); lsb_en = 1'b0; step();

    // rob_clear in cycle 10 of a fetch aborts it; next LSB granted at once
    if_pc = 32'h1000; if_en = 1'b1; g = cyc;
    repeat (10) step();
    rob_clear = 1'b1; if_en = 1'b0;
    step();
    check("rc_mem_wr", mem_wr, 1'b0);
    check("rc_if_done", if_done, 1'b0);
    rob_clear = 1'b0;
    lsb_exp_q.push_back(32'h00000009);
    lsb_start(1'b0, 32'h9, 3'd1, 32'h0); g = cyc;
    step();
    check("rc_lsb_a", mem_a, 32'h9);
    wait_done(1'b0, g, 20, lat);
    check("rc_lsb_lat", lat, 3);
    step(); lsb_en = 1'b0; step();

    // rst mid-fetch returns outputs to reset values, no done afterwards
    if_pc = 32'h1040; if_en = 1'b1;
    repeat (20) step();
    rst = 1'b1; if_en = 1'b0;
    step();
    check("mr_mem_a", mem_a, 32'h0);
    check("mr_mem_wr", mem_wr, 1'b0);
    check("mr_mem_dout", mem_dout, 8'h0);
    check("mr_if_data", if_data, 512'h0);
    check("mr_lsb_r_data", lsb_r_data, 32'h0);
    check("mr_if_done", if_done, 1'b0);
    step(); rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (if_done) nd++;
    end
    check("mr_no_done", nd, 0);

    check("if_q_empty", if_exp_q.size(), 0);
    check("lsb_q_empty", lsb_exp_q.size(), 0);
    check("wr_q_empty", wr_exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
